// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the byte-addressable data memory (synchronous write,
// asynchronous read), extracts/extends load data, owns the MEM/WB register and
// serves debug halt/readback.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned half/word accesses
// instead of silently aligning the address down).
module mem_access_stage #(
  parameter int unsigned NB_DATA    = 32,
  parameter int unsigned N_ADDRESS  = 64,
  parameter int unsigned NB_ADDRESS = $clog2(N_ADDRESS),
  parameter int unsigned NB_REG     = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [NB_DATA-1:0]    i_alu_result,
  input  logic [NB_DATA-1:0]    i_store_data,
  input  logic [NB_REG-1:0]     i_rd,
  input  logic                  i_reg_write,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [NB_DATA-1:0]    o_wb_data,
  output logic [NB_REG-1:0]     o_rd,
  output logic                  o_reg_write,
  output logic                  o_exc,
  output logic [NB_ADDRESS-1:0] o_mem_r_addr,
  output logic                  o_mem_r_en,
  output logic [1:0]            o_mem_r_addressing,
  output logic [NB_ADDRESS-1:0] o_mem_w_addr,
  output logic [NB_DATA-1:0]    o_mem_w_data,
  output logic                  o_mem_w_en,
  output logic [1:0]            o_mem_w_addressing,
  input  logic [NB_DATA-1:0]    i_mem_r_data,
  input  logic                  i_dbg_halt,
  output logic                  o_halted,
  input  logic [NB_ADDRESS-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0]    o_dbg_data
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [NB_DATA-1:0]    wb_q, wb_d;
  logic [NB_REG-1:0]     rd_q, rd_d;
  logic                  rw_q, rw_d;
  logic [NB_DATA-1:0]    dbg_q, dbg_d;
  logic                  acc, pop, misal;
  logic [1:0]            size_eff;
  logic [NB_ADDRESS-1:0] addr_raw, addr_eff;
  logic [NB_DATA-1:0]    load_data;

  // Size 10 behaves as a word access; address comes from the low ALU bits.
  assign size_eff = (i_size == 2'b10) ? 2'b00 : i_size;
  assign addr_raw = i_alu_result[NB_ADDRESS-1:0];

  // Alignment: either flag the access as misaligned or force the address down.
  always_comb begin
    addr_eff = addr_raw;
    misal    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (size_eff)
      2'b01:   misal = addr_raw[0];
      2'b00:   misal = |addr_raw[1:0];
      default: misal = 1'b0;
    endcase
`else
    case (size_eff)
      2'b01:   addr_eff[0]   = 1'b0;
      2'b00:   addr_eff[1:0] = 2'b00;
      default: ;
    endcase
`endif
  end

  assign o_ready = (state_q == StRun) & (~valid_q | i_ready) & ~i_flush & ~i_reset;
  assign acc     = i_valid & o_ready;
  assign pop     = valid_q & i_ready;

  // Memory ports: debug owns the read port while halted, otherwise gated by accept.
  always_comb begin
    o_mem_r_en         = 1'b0;
    o_mem_r_addr       = '0;
    o_mem_r_addressing = 2'b00;
    o_mem_w_en         = 1'b0;
    o_mem_w_addr       = '0;
    o_mem_w_data       = '0;
    o_mem_w_addressing = 2'b00;
    if (state_q == StHalted) begin
      o_mem_r_en   = 1'b1;
      o_mem_r_addr = i_dbg_addr;
    end else if (acc && !misal) begin
      if (i_mem_read) begin
        o_mem_r_en         = 1'b1;
        o_mem_r_addr       = addr_eff;
        o_mem_r_addressing = size_eff;
      end
      if (i_mem_write) begin
        o_mem_w_en         = 1'b1;
        o_mem_w_addr       = addr_eff;
        o_mem_w_data       = i_store_data;
        o_mem_w_addressing = size_eff;
      end
    end
  end

  // Little-endian extract with optional sign extension.
  always_comb begin
    case (size_eff)
      2'b01:   load_data = {{(NB_DATA-16){~i_unsigned & i_mem_r_data[15]}}, i_mem_r_data[15:0]};
      2'b11:   load_data = {{(NB_DATA-8){~i_unsigned & i_mem_r_data[7]}}, i_mem_r_data[7:0]};
      default: load_data = i_mem_r_data;
    endcase
  end

  // MEM/WB next state: pop clears, accept loads (back-to-back allowed), flush wins.
  always_comb begin
    valid_d = valid_q;
    wb_d    = wb_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    if (pop) valid_d = 1'b0;
    if (acc) begin
      valid_d = 1'b1;
      wb_d    = misal ? '0 : (i_mem_read ? load_data : i_alu_result);
      rd_d    = i_rd;
      rw_d    = i_reg_write & ~i_mem_write & ~misal;
    end
    if (i_flush) valid_d = 1'b0;
  end

  // Debug halt sequencing and readback capture.
  always_comb begin
    state_d = state_q;
    dbg_d   = dbg_q;
    unique case (state_q)
      StRun:    if (i_dbg_halt) state_d = StDrain;
      StDrain: begin
        if (!i_dbg_halt)   state_d = StRun;
        else if (!valid_q) state_d = StHalted;
      end
      StHalted: begin
        dbg_d = i_mem_r_data;
        if (!i_dbg_halt) state_d = StRun;
      end
      default:  state_d = StRun;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StRun;
      valid_q <= 1'b0;
      wb_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      dbg_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      dbg_q   <= dbg_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic exc_q, exc_d;

  // Exception flag lives exactly as long as its entry.
  always_comb begin
    exc_d = valid_d ? exc_q : 1'b0;
    if (acc) exc_d = misal;
  end

  // Exception register.
  always_ff @(posedge i_clk) begin
    if (i_reset) exc_q <= 1'b0;
    else         exc_q <= exc_d;
  end

  assign o_exc = exc_q;
`else
  assign o_exc = 1'b0;
`endif

  assign o_valid     = valid_q;
  assign o_wb_data   = wb_q;
  assign o_rd        = rd_q;
  assign o_reg_write = rw_q;
  assign o_halted    = (state_q == StHalted);
  assign o_dbg_data  = dbg_q;

endmodule
